// File: rtl/garage_occupancy_counter_pkg.sv
// Shared definitions for the garage occupancy counter:
// gate FSM encodings, default count width and a width helper.
package garage_occupancy_counter_pkg;

    typedef enum logic [1:0] {
        GATE_IDLE = 2'd0,
        GATE_OPEN = 2'd1,
        GATE_HOLD = 2'd2
    } gate_state_e;

    localparam int CNT_W_DEF = 6;
    localparam int GATE_IN   = 0;
    localparam int GATE_OUT  = 1;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/garage_occupancy_counter_debounce.sv
// Sensor front end: 2-flop synchroniser, level debounce
// and a one-cycle pulse on each accepted rising level.
module garage_occupancy_counter_debounce
    import garage_occupancy_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_raw,
    output logic level,
    output logic arrival
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] RUN_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [DW-1:0] run_q;
    logic [DW-1:0] run_d;

    // run_q counts consecutive samples that disagree with the accepted level.
    always_comb begin
        level_d = level_q;
        run_d   = '0;
        if (sync2_q != level_q) begin
            if (run_q == RUN_LAST) begin
                level_d = ~level_q;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            run_q        <= '0;
        end else begin
            sync1_q      <= sensor_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            run_q        <= run_d;
        end
    end

    assign level   = level_q;
    assign arrival = level_q & ~level_prev_q;

endmodule

// File: rtl/garage_occupancy_counter.sv
// Garage occupancy counter: debounced entry/exit sensors, per-gate
// barrier FSMs and a saturating car count with full/empty status.
module garage_occupancy_counter
    import garage_occupancy_counter_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEF,
    parameter int CAPACITY        = 50,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_CYCLES     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             gate_in_open,
    output logic             gate_out_open,
    output logic             entry_denied
);

    localparam int TW = cnt_width(GATE_CYCLES);
    localparam logic [TW-1:0]    T_LOAD = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);

    logic [1:0]       sens_raw;
    logic [1:0]       db_lvl;
    logic [1:0]       db_arr;
    logic [1:0]       start;
    logic [1:0]       gate_go;
    logic             in_acc;
    logic             out_acc;

    gate_state_e      state_q [2];
    gate_state_e      state_d [2];
    logic [TW-1:0]    timer_q [2];
    logic [TW-1:0]    timer_d [2];

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             full_d;
    logic             empty_q;
    logic             empty_d;
    logic             deny_q;
    logic             deny_d;

    assign sens_raw = {exit_sensor, entry_sensor};

    for (genvar s = 0; s < 2; s++) begin : g_sensor
        garage_occupancy_counter_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk       (clk),
            .reset     (reset),
            .sensor_raw(sens_raw[s]),
            .level     (db_lvl[s]),
            .arrival   (db_arr[s])
        );
    end

    // A same-cycle exit frees the slot the entering car needs.
    always_comb begin
        start[GATE_IN]  = db_arr[GATE_IN]  && (state_q[GATE_IN]  == GATE_IDLE);
        start[GATE_OUT] = db_arr[GATE_OUT] && (state_q[GATE_OUT] == GATE_IDLE);
        out_acc = start[GATE_OUT] && (count_q != '0);
        in_acc  = start[GATE_IN] && ((count_q < CAP) || out_acc);
        deny_d  = start[GATE_IN] && !in_acc;
        gate_go = {start[GATE_OUT], in_acc};
        count_d = count_q;
        if (in_acc && !out_acc) begin
            count_d = count_q + 1'b1;
        end else if (out_acc && !in_acc) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == CAP);
        empty_d = (count_d == '0);
    end

    for (genvar g = 0; g < 2; g++) begin : g_gate
        always_comb begin
            state_d[g] = state_q[g];
            timer_d[g] = timer_q[g];
            unique case (state_q[g])
                GATE_IDLE: begin
                    if (gate_go[g]) begin
                        state_d[g] = GATE_OPEN;
                        timer_d[g] = T_LOAD;
                    end
                end
                GATE_OPEN: begin
                    if (timer_q[g] == '0) begin
                        state_d[g] = db_lvl[g] ? GATE_HOLD : GATE_IDLE;
                    end else begin
                        timer_d[g] = timer_q[g] - 1'b1;
                    end
                end
                GATE_HOLD: begin
                    if (!db_lvl[g]) begin
                        state_d[g] = GATE_IDLE;
                    end
                end
                default: begin
                    state_d[g] = GATE_IDLE;
                    timer_d[g] = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q[g] <= GATE_IDLE;
                timer_q[g] <= '0;
            end else begin
                state_q[g] <= state_d[g];
                timer_q[g] <= timer_d[g];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            deny_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            deny_q  <= deny_d;
        end
    end

    assign count         = count_q;
    assign full          = full_q;
    assign empty         = empty_q;
    assign entry_denied  = deny_q;
    assign gate_in_open  = (state_q[GATE_IN]  != GATE_IDLE);
    assign gate_out_open = (state_q[GATE_OUT] != GATE_IDLE);

endmodule

// File: tb/tb_garage_occupancy_counter.sv
// Bench for garage_occupancy_counter: directed scenarios plus random
// sensor traffic, all compared cycle by cycle against a timing model.
module tb_garage_occupancy_counter;

    localparam int CAP = 3;
    localparam int DB  = 2;
    localparam int GC  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       entry_sensor;
    logic       exit_sensor;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       gate_in_open;
    logic       gate_out_open;
    logic       entry_denied;

    always #5 clk = ~clk;

    garage_occupancy_counter #(
        .CNT_W          (6),
        .CAPACITY       (CAP),
        .DEBOUNCE_CYCLES(DB),
        .GATE_CYCLES    (GC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .entry_sensor (entry_sensor),
        .exit_sensor  (exit_sensor),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .gate_in_open (gate_in_open),
        .gate_out_open(gate_out_open),
        .entry_denied (entry_denied)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: sensor history window, gate open intervals, count.
    int cyc = 0;
    int m_count;
    bit m_full, m_empty, m_deny;
    bit m_lvl_in, m_lvl_out, m_rise_in, m_rise_out;
    bit m_open_in, m_open_out;
    int since_in, since_out;
    bit hq_in[$];
    bit hq_out[$];

    // Level flips when the last DB synchronised samples all disagree with it;
    // the synchronised sample at this edge is the raw value two edges back.
    function automatic bit settles(input bit q[$], input bit lvl);
        for (int i = 1; i <= DB; i++) begin
            if (q[q.size() - 1 - i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit x);
        bit go_in, go_out, acc_in, acc_out, nl;
        if (r) begin
            m_count = 0;
            m_deny = 0;
            m_open_in = 0;
            m_open_out = 0;
            m_lvl_in = 0;
            m_lvl_out = 0;
            m_rise_in = 0;
            m_rise_out = 0;
            hq_in = {};
            hq_out = {};
            repeat (DB + 2) begin
                hq_in.push_back(1'b0);
                hq_out.push_back(1'b0);
            end
        end else begin
            go_in   = m_rise_in && !m_open_in;
            go_out  = m_rise_out && !m_open_out;
            acc_out = go_out && (m_count > 0);
            acc_in  = go_in && ((m_count < CAP) || acc_out);
            m_deny  = go_in && !acc_in;
            m_count = m_count + int'(acc_in) - int'(acc_out);
            if (m_open_in && cyc >= since_in + GC && !m_lvl_in) m_open_in = 0;
            if (m_open_out && cyc >= since_out + GC && !m_lvl_out) m_open_out = 0;
            if (acc_in) begin
                m_open_in = 1;
                since_in = cyc;
            end
            if (go_out) begin
                m_open_out = 1;
                since_out = cyc;
            end
            nl = settles(hq_in, m_lvl_in) ? !m_lvl_in : m_lvl_in;
            m_rise_in = nl && !m_lvl_in;
            m_lvl_in = nl;
            nl = settles(hq_out, m_lvl_out) ? !m_lvl_out : m_lvl_out;
            m_rise_out = nl && !m_lvl_out;
            m_lvl_out = nl;
            hq_in.push_back(e);
            hq_out.push_back(x);
            if (hq_in.size() > DB + 2) void'(hq_in.pop_front());
            if (hq_out.size() > DB + 2) void'(hq_out.pop_front());
        end
        m_full = (m_count == CAP);
        m_empty = (m_count == 0);
        cyc++;
    endtask

    bit saw_deny, saw_gin, saw_gout;

    task automatic clear_saw();
        saw_deny = 0;
        saw_gin = 0;
        saw_gout = 0;
    endtask

    task automatic tick(input bit r, input bit e, input bit x);
        reset = r;
        entry_sensor = e;
        exit_sensor = x;
        @(posedge clk);
        model_edge(r, e, x);
        #1;
        check("count", count, m_count);
        check("full", full, m_full);
        check("empty", empty, m_empty);
        check("gate_in", gate_in_open, m_open_in);
        check("gate_out", gate_out_open, m_open_out);
        check("deny", entry_denied, m_deny);
        saw_deny |= entry_denied;
        saw_gin |= gate_in_open;
        saw_gout |= gate_out_open;
    endtask

    task automatic car(input bit e, input bit x, input int hi, input int lo);
        repeat (hi) tick(1'b0, e, x);
        repeat (lo) tick(1'b0, 1'b0, 1'b0);
    endtask

    bit e_lvl, x_lvl;
    int e_dur, x_dur;

    initial begin
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_gates", {gate_in_open, gate_out_open}, 0);
        check("rst_deny", entry_denied, 0);

        tick(1'b0, 1'b1, 1'b0);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        check("glitch_count", count, 0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b1, 1'b0);
        check("bounce_count", count, 1);
        check("hold_open", gate_in_open, 1);
        repeat (8) tick(1'b0, 1'b0, 1'b0);
        check("hold_closed", gate_in_open, 0);

        repeat (7) tick(1'b0, 1'b1, 1'b0);
        check("pre_rst_count", count, 2);
        check("pre_rst_open", gate_in_open, 1);
        tick(1'b1, 1'b0, 1'b0);
        check("mid_rst_gate", gate_in_open, 0);
        tick(1'b1, 1'b0, 1'b0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);

        repeat (3) car(1'b1, 1'b0, 6, 8);
        check("fill_count", count, 3);
        check("fill_full", full, 1);
        clear_saw();
        car(1'b1, 1'b0, 6, 8);
        check("deny_pulse", saw_deny, 1);
        check("deny_gate", saw_gin, 0);
        check("deny_count", count, 3);

        clear_saw();
        repeat (6) tick(1'b0, 1'b1, 1'b1);
        check("swap_count", count, 3);
        check("swap_gates", {gate_in_open, gate_out_open}, 2'b11);
        check("swap_deny", saw_deny, 0);
        repeat (8) tick(1'b0, 1'b0, 1'b0);

        repeat (3) car(1'b0, 1'b1, 6, 8);
        check("drain_count", count, 0);
        clear_saw();
        car(1'b0, 1'b1, 6, 8);
        check("empty_exit_gate", saw_gout, 1);
        check("empty_exit_count", count, 0);
        check("empty_exit_empty", empty, 1);

        e_lvl = 0;
        x_lvl = 0;
        e_dur = 0;
        x_dur = 0;
        for (int i = 0; i < 10000; i++) begin
            if (e_dur == 0) begin
                e_lvl = 1'($urandom_range(0, 1));
                e_dur = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 20));
            end
            if (x_dur == 0) begin
                x_lvl = 1'($urandom_range(0, 1));
                x_dur = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 20));
            end
            e_dur--;
            x_dur--;
            tick($urandom_range(0, 2999) == 0, e_lvl, x_lvl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
